// File: rtl/alu_seq.sv
// alu_seq: registered multi-cycle ALU with NZCV flag register and start/done handshake.
// Executes the 16 processor func codes; non-shift ops finish on the accept edge,
// shifts step one bit per cycle in the SHIFT state.
// Optional feature macro: ALU_BARREL_EN -- when defined, LSL/LSR finish in a single cycle
// through a barrel shifter and the SHIFT state is never entered.
module alu_seq #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       func,
    input  logic [WIDTH-1:0] OP0,
    input  logic [WIDTH-1:0] OP1,
    input  logic             flag_en,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Q,
    output logic [3:0]       flag_out,
    output logic             b_out
);

    localparam logic [3:0] F_JMP = 4'h0;
    localparam logic [3:0] F_ADD = 4'h1;
    localparam logic [3:0] F_SUB = 4'h2;
    localparam logic [3:0] F_LSL = 4'h3;
    localparam logic [3:0] F_LSR = 4'h4;
    localparam logic [3:0] F_AND = 4'h5;
    localparam logic [3:0] F_OR  = 4'h6;
    localparam logic [3:0] F_XOR = 4'h7;
    localparam logic [3:0] F_LD  = 4'h8;
    localparam logic [3:0] F_ST  = 4'h9;
    localparam logic [3:0] F_MOV = 4'hA;
    localparam logic [3:0] F_BEQ = 4'hB;
    localparam logic [3:0] F_BNE = 4'hC;
    localparam logic [3:0] F_BLT = 4'hD;
    localparam logic [3:0] F_BGT = 4'hE;
    localparam logic [3:0] F_CMP = 4'hF;

    localparam logic [WIDTH-1:0] WIDTH_OP = WIDTH'(WIDTH);
    localparam logic [SHW-1:0]   WIDTH_N  = SHW'(WIDTH);
    localparam logic [SHW-1:0]   CNT_ONE  = SHW'(1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [3:0]       flag_q, flag_d;
    logic             b_q, b_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] sh_val_q, sh_val_d;
    logic [SHW-1:0]   sh_cnt_q, sh_cnt_d;
    logic             sh_left_q, sh_left_d;
    logic             sh_fe_q, sh_fe_d;

    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   sub_sum;
    logic             add_v;
    logic             sub_v;
    logic [SHW-1:0]   n_clamp;
    logic [WIDTH-1:0] step_val;
    logic             step_c;
    logic             flag_z, flag_n, flag_v;

    // Flag word layout {C,N,V,Z}; N and Z always come from the freshly computed result.
    function automatic logic [3:0] mk_flags(input logic c, input logic v, input logic [WIDTH-1:0] r);
        return {c, r[WIDTH-1], v, (r == '0)};
    endfunction

`ifdef ALU_BARREL_EN
    logic [WIDTH:0] shres;

    // Returns {C,Q}; the extra top bit catches the last bit shifted out (0 when n=0).
    function automatic logic [WIDTH:0] barrel_lsl(input logic [WIDTH-1:0] a, input logic [SHW-1:0] n);
        logic [WIDTH:0] w;
        w = {1'b0, a} << n;
        return w;
    endfunction

    // Returns {C,Q}; the extra bottom bit catches the last bit shifted out (0 when n=0).
    function automatic logic [WIDTH:0] barrel_lsr(input logic [WIDTH-1:0] a, input logic [SHW-1:0] n);
        logic [WIDTH:0] w;
        w = {a, 1'b0} >> n;
        return {w[0], w[WIDTH:1]};
    endfunction
`endif

    assign add_sum = {1'b0, OP0} + {1'b0, OP1};
    assign sub_sum = {1'b0, OP0} + {1'b0, ~OP1} + {{WIDTH{1'b0}}, 1'b1};
    assign add_v   = (OP0[WIDTH-1] == OP1[WIDTH-1]) && (add_sum[WIDTH-1] != OP0[WIDTH-1]);
    assign sub_v   = (OP0[WIDTH-1] != OP1[WIDTH-1]) && (sub_sum[WIDTH-1] != OP0[WIDTH-1]);

    // Shift counts beyond the datapath width behave exactly like a full-width shift.
    assign n_clamp = (OP1 >= WIDTH_OP) ? WIDTH_N : OP1[SHW-1:0];

    assign step_c   = sh_left_q ? sh_val_q[WIDTH-1] : sh_val_q[0];
    assign step_val = sh_left_q ? {sh_val_q[WIDTH-2:0], 1'b0} : {1'b0, sh_val_q[WIDTH-1:1]};

    // Branch conditions read the flag register as it stands when the branch is accepted.
    assign flag_z = flag_q[0];
    assign flag_v = flag_q[1];
    assign flag_n = flag_q[2];

    assign busy     = (state_q == SHIFT);
    assign done     = done_q;
    assign Q        = q_q;
    assign flag_out = flag_q;
    assign b_out    = b_q;

    // Next-state and next-register logic: issue/execute in IDLE, bit-serial stepping in SHIFT.
    always_comb begin
        state_d   = state_q;
        q_d       = q_q;
        flag_d    = flag_q;
        b_d       = b_q;
        done_d    = 1'b0;
        sh_val_d  = sh_val_q;
        sh_cnt_d  = sh_cnt_q;
        sh_left_d = sh_left_q;
        sh_fe_d   = sh_fe_q;
`ifdef ALU_BARREL_EN
        shres     = '0;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    done_d = 1'b1;
                    b_d    = 1'b0;
                    case (func)
                        F_JMP: begin
                            q_d = OP1;
                            b_d = 1'b1;
                        end
                        F_ADD: begin
                            q_d = add_sum[WIDTH-1:0];
                            if (flag_en) flag_d = mk_flags(add_sum[WIDTH], add_v, add_sum[WIDTH-1:0]);
                        end
                        F_SUB, F_CMP: begin
                            q_d = sub_sum[WIDTH-1:0];
                            if (flag_en || (func == F_CMP))
                                flag_d = mk_flags(sub_sum[WIDTH], sub_v, sub_sum[WIDTH-1:0]);
                        end
                        F_LSL, F_LSR: begin
`ifdef ALU_BARREL_EN
                            shres = (func == F_LSL) ? barrel_lsl(OP0, n_clamp) : barrel_lsr(OP0, n_clamp);
                            q_d   = shres[WIDTH-1:0];
                            if (flag_en) flag_d = mk_flags(shres[WIDTH], 1'b0, shres[WIDTH-1:0]);
`else
                            if (n_clamp == '0) begin
                                q_d = OP0;
                                if (flag_en) flag_d = mk_flags(1'b0, 1'b0, OP0);
                            end else begin
                                // Defer completion: b_out keeps its value until the shift finishes.
                                done_d    = 1'b0;
                                b_d       = b_q;
                                state_d   = SHIFT;
                                sh_val_d  = OP0;
                                sh_cnt_d  = n_clamp;
                                sh_left_d = (func == F_LSL);
                                sh_fe_d   = flag_en;
                            end
`endif
                        end
                        F_AND: begin
                            q_d = OP0 & OP1;
                            if (flag_en) flag_d = mk_flags(1'b0, 1'b0, OP0 & OP1);
                        end
                        F_OR: begin
                            q_d = OP0 | OP1;
                            if (flag_en) flag_d = mk_flags(1'b0, 1'b0, OP0 | OP1);
                        end
                        F_XOR: begin
                            q_d = OP0 ^ OP1;
                            if (flag_en) flag_d = mk_flags(1'b0, 1'b0, OP0 ^ OP1);
                        end
                        F_LD, F_ST, F_MOV: begin
                            q_d = add_sum[WIDTH-1:0];
                        end
                        F_BEQ: begin
                            q_d = OP1;
                            b_d = flag_z;
                        end
                        F_BNE: begin
                            q_d = OP1;
                            b_d = !flag_z;
                        end
                        F_BLT: begin
                            q_d = OP1;
                            b_d = (flag_n != flag_v);
                        end
                        F_BGT: begin
                            q_d = OP1;
                            b_d = !flag_z && (flag_n == flag_v);
                        end
                        default: ;
                    endcase
                end
            end
            SHIFT: begin
                sh_val_d = step_val;
                sh_cnt_d = sh_cnt_q - CNT_ONE;
                if (sh_cnt_q == CNT_ONE) begin
                    // Last bit: its shifted-out value becomes C.
                    q_d     = step_val;
                    if (sh_fe_q) flag_d = mk_flags(step_c, 1'b0, step_val);
                    b_d     = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and architectural registers; reset drops any in-flight op without touching flags further.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            q_q     <= '0;
            flag_q  <= '0;
            b_q     <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            flag_q  <= flag_d;
            b_q     <= b_d;
            done_q  <= done_d;
        end
    end

    // Shifter working registers; only meaningful while in SHIFT, so they carry no reset.
    always_ff @(posedge clk) begin
        sh_val_q  <= sh_val_d;
        sh_cnt_q  <= sh_cnt_d;
        sh_left_q <= sh_left_d;
        sh_fe_q   <= sh_fe_d;
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: scoreboard bench for alu_seq (WIDTH=16). Expected results come from a
// behavioural model evaluated at issue time; a negedge monitor pops them on done.
module tb_alu_seq;

    localparam int W = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [3:0]    func;
    logic [W-1:0]  OP0, OP1;
    logic          flag_en;
    logic          busy, done, b_out;
    logic [W-1:0]  Q;
    logic [3:0]    flag_out;

    typedef struct {
        logic [W-1:0] q;
        logic [3:0]   fl;
        logic         b;
        int           cyc;
    } exp_t;

    exp_t       sb[$];
    exp_t       me;
    logic [3:0] mflags;
    int         cyc = 0;
    int         n_checks = 0;
    int         n_errors = 0;

    alu_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .func(func), .OP0(OP0), .OP1(OP1),
        .flag_en(flag_en), .busy(busy), .done(done), .Q(Q), .flag_out(flag_out), .b_out(b_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Behavioural reference: computes the expected completion, pushes it, then pulses start.
    task automatic drive(input logic [3:0] f, input logic [W-1:0] a, input logic [W-1:0] bb, input logic fe);
        exp_t         e;
        int           n;
        int           lat;
        logic [W:0]   s;
        logic [W-1:0] v;
        logic         c, ov, upd;
        n   = (bb > 16'd16) ? 16 : int'(bb);
        upd = 1'b0; c = 1'b0; ov = 1'b0; v = '0; e.b = 1'b0;
        case (f)
            4'h0: begin v = bb; e.b = 1'b1; end
            4'h1: begin
                s = {1'b0, a} + {1'b0, bb}; v = s[W-1:0]; c = s[W];
                ov = (a[W-1] == bb[W-1]) && (v[W-1] != a[W-1]); upd = fe;
            end
            4'h2, 4'hF: begin
                s = {1'b0, a} - {1'b0, bb}; v = s[W-1:0]; c = (a >= bb);
                ov = (a[W-1] != bb[W-1]) && (v[W-1] != a[W-1]); upd = fe || (f == 4'hF);
            end
            4'h3: begin
                v = a;
                for (int i = 0; i < n; i++) begin c = v[W-1]; v = v << 1; end
                upd = fe;
            end
            4'h4: begin
                v = a;
                for (int i = 0; i < n; i++) begin c = v[0]; v = v >> 1; end
                upd = fe;
            end
            4'h5: begin v = a & bb; upd = fe; end
            4'h6: begin v = a | bb; upd = fe; end
            4'h7: begin v = a ^ bb; upd = fe; end
            4'h8, 4'h9, 4'hA: v = a + bb;
            4'hB: begin v = bb; e.b = mflags[0]; end
            4'hC: begin v = bb; e.b = !mflags[0]; end
            4'hD: begin v = bb; e.b = (mflags[2] != mflags[1]); end
            default: begin v = bb; e.b = !mflags[0] && (mflags[2] == mflags[1]); end
        endcase
        e.q = v;
        if (upd) mflags = {c, v[W-1], ov, (v == '0)};
        e.fl = mflags;
`ifdef ALU_BARREL_EN
        lat = 1;
`else
        lat = (f == 4'h3 || f == 4'h4) ? 1 + n : 1;
`endif
        e.cyc = cyc + lat;
        sb.push_back(e);
        func = f; OP0 = a; OP1 = bb; flag_en = fe; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        int k = 0;
        while (!done && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (!done) chk("done_timeout", 32'd0, 32'd1);
    endtask

    // Scoreboard monitor: every done must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb.size() == 0) begin
                chk("spurious_done", 32'd1, 32'd0);
            end else begin
                me = sb.pop_front();
                chk("Q", 32'(Q), 32'(me.q));
                chk("flags", 32'(flag_out), 32'(me.fl));
                chk("b_out", 32'(b_out), 32'(me.b));
                chk("latency", cyc, me.cyc);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; start = 1'b0; func = '0; OP0 = '0; OP1 = '0; flag_en = 1'b0;
        mflags = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_Q", 32'(Q), 32'd0);
        chk("rst_flags", 32'(flag_out), 32'd0);
        chk("rst_b", 32'(b_out), 32'd0);
        rst = 1'b0;

        // Signed overflow on ADD.
        drive(4'h1, 16'h7FFF, 16'h0001, 1'b1); wait_done();
        chk("add_ovf_flags", 32'(flag_out), 32'h6);
        // Zero result on SUB, then AND without flag update (back-to-back issue).
        drive(4'h2, 16'h0005, 16'h0005, 1'b1); wait_done();
        chk("sub_zero_flags", 32'(flag_out), 32'h9);
        drive(4'h5, 16'hF0F0, 16'h0F0F, 1'b0); wait_done();
        chk("and_keep_flags", 32'(flag_out), 32'h9);

        // LSL by 4: busy for 4 cycles, done on the 5th.
        drive(4'h3, 16'h1001, 16'd4, 1'b1);
`ifndef ALU_BARREL_EN
        for (int i = 0; i < 4; i++) begin
            chk("lsl_busy", 32'(busy), 32'd1);
            @(negedge clk);
        end
`endif
        chk("lsl_busy_end", 32'(busy), 32'd0);
        wait_done();

        // LSR by an over-range count, with a start pulse mid-shift that must be ignored.
        drive(4'h4, 16'hFFFF, 16'd20, 1'b1);
`ifndef ALU_BARREL_EN
        repeat (3) @(negedge clk);
        chk("lsr_busy_mid", 32'(busy), 32'd1);
        func = 4'h1; OP0 = 16'h0001; OP1 = 16'h0001; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
`endif
        wait_done();
        repeat (4) @(negedge clk);

        // CMP then signed branches.
        drive(4'hF, 16'h0003, 16'h0007, 1'b0); wait_done();
        drive(4'hD, 16'h1234, 16'h0040, 1'b0); wait_done();
        drive(4'hE, 16'h1234, 16'h0080, 1'b0); wait_done();
        drive(4'hB, 16'h0000, 16'h0100, 1'b0); wait_done();
        drive(4'hC, 16'h0000, 16'h0200, 1'b0); wait_done();
        // JMP, address ops, carry wrap, borrow, zero/full-width shifts.
        drive(4'h0, 16'hAAAA, 16'h0300, 1'b1); wait_done();
        drive(4'h8, 16'hFFF0, 16'h0020, 1'b1); wait_done();
        drive(4'hA, 16'h1111, 16'h2222, 1'b1); wait_done();
        drive(4'h1, 16'hFFFF, 16'h0001, 1'b1); wait_done();
        drive(4'h2, 16'h0001, 16'h0002, 1'b1); wait_done();
        drive(4'h3, 16'h8001, 16'd0, 1'b1); wait_done();
        drive(4'h3, 16'h0001, 16'd16, 1'b1); wait_done();
        drive(4'h4, 16'h8000, 16'd15, 1'b1); wait_done();
        drive(4'h6, 16'h8000, 16'h0001, 1'b1); wait_done();
        drive(4'h7, 16'h00FF, 16'h00FF, 1'b1); wait_done();
        drive(4'hB, 16'h0000, 16'h0400, 1'b0); wait_done();

        // Reset in the middle of a shift: op dropped, state cleared, next issue accepted.
        drive(4'h3, 16'h00FF, 16'd8, 1'b1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        sb.delete();
        mflags = '0;
        @(negedge clk);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_Q", 32'(Q), 32'd0);
        chk("midrst_flags", 32'(flag_out), 32'd0);
        rst = 1'b0;
        drive(4'h1, 16'h0002, 16'h0003, 1'b1); wait_done();

        // Randomised mix of all func codes.
        for (int i = 0; i < 60; i++) begin
            logic [3:0]   rf;
            logic [W-1:0] ra, rb;
            rf = 4'($urandom_range(0, 15));
            ra = 16'($urandom);
            rb = (rf == 4'h3 || rf == 4'h4) ? 16'($urandom_range(0, 20)) : 16'($urandom);
            if (i % 7 == 0) rb = ra;
            drive(rf, ra, rb, 1'($urandom_range(0, 1)));
            wait_done();
        end

        repeat (5) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
